ddr_req_scheduler: RTL

//  Single-owner scheduler for the shared DDR port. It arbitrates three requesters: frontend fetch burst (pc),
//  LSU store (opstore) and LSU load (opload). It latches the winning request, issues it to DDR and tracks the

---
 rtl/ddr_req_scheduler.sv | 98 +++++++++
 1 files changed

// File: rtl/ddr_req_scheduler.sv
// ddr_req_scheduler: arbitrates fetch/store/load requesters onto a single-outstanding DDR port
module ddr_req_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int IDX_W = 19
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pc_index_valid,
  input  logic [IDX_W-1:0] pc_index,
  output logic             pc_index_ready,
  output logic [511:0]     pc_read_inst,
  output logic             pc_operation_done,
  input  logic             opstore_index_valid,
  input  logic [IDX_W-1:0] opstore_index,
  input  logic [63:0]      opstore_write_mask,
  input  logic [63:0]      opstore_write_data,
  output logic             opstore_index_ready,
  output logic             opstore_operation_done,
  input  logic             opload_index_valid,
  input  logic [IDX_W-1:0] opload_index,
  output logic             opload_index_ready,
  output logic [63:0]      opload_read_data,
  output logic             opload_operation_done,
  input  logic             redirect_valid,
  output logic             ddr_chip_enable,
  output logic [IDX_W-1:0] ddr_index,
  output logic             ddr_write_enable,
  output logic             ddr_burst_mode,
  output logic [63:0]      ddr_opstore_write_mask,
  output logic [63:0]      ddr_opstore_write_data,
  input  logic [63:0]      ddr_opload_read_data,
  input  logic [511:0]     ddr_pc_read_inst,
  input  logic             ddr_operation_done,
  input  logic             ddr_ready
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_PC = 2'd1;
  localparam logic [1:0] OWN_ST = 2'd2;
  localparam logic [1:0] OWN_LD = 2'd3;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_t state_q, state_d;
  logic [1:0] owner_q, owner_d, win;
  logic kill_q, kill_d;
  logic [3:0] starve_q, starve_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [63:0] mask_q, mask_d, data_q, data_d;
  logic pc_ok, hs, done;
  always_comb begin
    pc_ok = pc_index_valid && !redirect_valid;
    win = (pc_ok && starve_q == LIMIT) ? OWN_PC :
          opstore_index_valid ? OWN_ST :
          opload_index_valid ? OWN_LD :
          pc_ok ? OWN_PC : OWN_NONE;
    hs = state_q == IDLE && ddr_ready && win != OWN_NONE;
    done = state_q == WAIT && ddr_operation_done;
    state_d = hs ? ISSUE : state_q == ISSUE ? WAIT : done ? IDLE : state_q;
    owner_d = hs ? win : done ? OWN_NONE : owner_q;
    idx_d = !hs ? idx_q : win == OWN_PC ? pc_index : win == OWN_ST ? opstore_index : opload_index;
    mask_d = hs ? (win == OWN_ST ? opstore_write_mask : '0) : done ? '0 : mask_q;
    data_d = hs ? (win == OWN_ST ? opstore_write_data : '0) : done ? '0 : data_q;
    kill_d = state_q != IDLE && (kill_q || (owner_q == OWN_PC && redirect_valid));
    starve_d = (!pc_index_valid || (hs && win == OWN_PC)) ? '0 :
               (hs && starve_q != LIMIT) ? starve_q + 4'd1 : starve_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= OWN_NONE;
      kill_q <= 1'b0;
      starve_q <= '0;
      idx_q <= '0;
      mask_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      kill_q <= kill_d;
      starve_q <= starve_d;
      idx_q <= idx_d;
      mask_q <= mask_d;
      data_q <= data_d;
    end
  assign pc_index_ready = state_q == IDLE && ddr_ready && win == OWN_PC;
  assign opstore_index_ready = state_q == IDLE && ddr_ready && win == OWN_ST;
  assign opload_index_ready = state_q == IDLE && ddr_ready && win == OWN_LD;
  assign pc_operation_done = done && owner_q == OWN_PC && !kill_q && !redirect_valid;
  assign opstore_operation_done = done && owner_q == OWN_ST;
  assign opload_operation_done = done && owner_q == OWN_LD;
  assign pc_read_inst = ddr_pc_read_inst;
  assign opload_read_data = ddr_opload_read_data;
  assign ddr_chip_enable = state_q == ISSUE;
  assign ddr_index = idx_q;
  assign ddr_write_enable = owner_q == OWN_ST;
  assign ddr_burst_mode = owner_q == OWN_PC;
  assign ddr_opstore_write_mask = mask_q;
  assign ddr_opstore_write_data = data_q;
endmodule
